// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned IMEM_WORDS  = 1024;

endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready output register; flush drops the entry regardless of ready.
module fetch_slot #(
    parameter int unsigned PC_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            ready_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [31:0]     instr_o,
    output logic            free_o
);

    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC sequencing, redirect/fault handling and one-entry output slot.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned PC_W     = 64
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_pc,
    input  logic [31:0]     imem_instr,
    input  logic            imem_inv,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            fault,
    output logic [PC_W-1:0] fault_pc,
    input  logic            fault_clear,
    output logic [31:0]     fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     count_q, count_d;
    logic            load, flush, slot_free;

    fetch_slot #(.PC_W(PC_W)) u_slot (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .flush_i (flush),
        .ready_i (if_ready),
        .pc_i    (pc_q),
        .instr_i (imem_instr),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .instr_o (if_instr),
        .free_o  (slot_free)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        load       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN, FAULT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    flush   = 1'b1;
                    state_d = RUN;
                end else if (state_q == FAULT) begin
                    if (fault_clear) state_d = RUN;
                end else if (slot_free && !stall) begin
                    if (imem_inv) begin
                        fault_pc_d = pc_q;
                        state_d    = FAULT;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_q + PC_W'(INSTR_BYTES);
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // A handshake coinciding with a redirect is a flush, not an accept.
    always_comb begin
        count_d = count_q;
        if (if_valid && if_ready && !flush) count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= PC_W'(RESET_PC);
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    assign imem_pc     = pc_q;
    assign fault       = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a behavioural 1024-word instruction memory.
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        imem_inv;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        fault;
    logic [63:0] fault_pc;
    logic        fault_clear = 1'b0;
    logic [31:0] fetch_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned exp_count = 0;
    exp_t        sb[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_instr = mem_word(imem_pc);
    assign imem_inv   = (imem_pc[1:0] != 2'b00) || (imem_pc >= 64'(IMEM_WORDS * INSTR_BYTES));

    fetch_controller #(.RESET_PC(64'h0), .PC_W(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .imem_inv       (imem_inv),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fault_clear    (fault_clear),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [63:0] pc);
        sb.push_back('{pc: pc, instr: mem_word(pc)});
    endtask

    // Scores the handshake presented this cycle, then advances to 1 time unit past the next edge.
    task automatic cycle();
        exp_t e;
        if (if_valid && if_ready && !redirect_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow got pc %0h with no expected entry", if_pc);
            end else begin
                e = sb.pop_front();
                exp_count++;
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    errors++;
                    $display("FAIL sb_accept got pc %0h instr %0h exp pc %0h instr %0h",
                             if_pc, if_instr, e.pc, e.instr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        fault_clear    = 1'b0;
        if_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_count = 0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (imem_pc !== 64'h0 || if_valid !== 1'b0 || if_pc !== 64'h0 || if_instr !== 32'h0 ||
            fault !== 1'b0 || fault_pc !== 64'h0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got pc %0h v %b ifpc %0h ins %0h f %b fpc %0h cnt %0d exp all zero",
                     imem_pc, if_valid, if_pc, if_instr, fault, fault_pc, fetch_count);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        if_ready = 1'b1;
        push(64'h0); push(64'h4); push(64'h8); push(64'hC); push(64'h10);
        checks++;
        if (imem_pc !== 64'h0) begin errors++; $display("FAIL seq_c0_pc got %0h exp 0", imem_pc); end
        cycle();
        checks++;
        if (imem_pc !== 64'h0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL seq_c1 got pc %0h v %b exp pc 0 v 0", imem_pc, if_valid);
        end
        cycle();
        checks++;
        if (imem_pc !== 64'h4 || if_valid !== 1'b1 || if_pc !== 64'h0) begin
            errors++; $display("FAIL seq_c2 got pc %0h v %b ifpc %0h exp 4 1 0", imem_pc, if_valid, if_pc);
        end
        cycle();
        checks++;
        if (imem_pc !== 64'h8 || if_pc !== 64'h4) begin
            errors++; $display("FAIL seq_c3 got pc %0h ifpc %0h exp 8 4", imem_pc, if_pc);
        end
        cycle();
        checks++;
        if (if_pc !== 64'h8) begin errors++; $display("FAIL seq_c4 got ifpc %0h exp 8", if_pc); end
        cycle();
        checks++;
        if (fetch_count !== 32'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", fetch_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        if_ready = 1'b1;
        push(64'h0); push(64'h4); push(64'h8); push(64'hC); push(64'h10);
        repeat (4) cycle();
        checks++;
        if (if_pc !== 64'h8) begin errors++; $display("FAIL bp_start got ifpc %0h exp 8", if_pc); end
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (if_pc !== 64'h8 || imem_pc !== 64'hC || if_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d got ifpc %0h pc %0h v %b exp 8 c 1", i, if_pc, imem_pc, if_valid);
            end
        end
        if_ready = 1'b1;
        cycle();
        checks++;
        if (if_pc !== 64'hC || imem_pc !== 64'h10) begin
            errors++; $display("FAIL bp_release got ifpc %0h pc %0h exp c 10", if_pc, imem_pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        if_ready = 1'b1;
        stall    = 1'b1;
        push(64'h0); push(64'h4);
        repeat (3) cycle();
        checks++;
        if (imem_pc !== 64'h0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold got pc %0h v %b exp 0 0", imem_pc, if_valid);
        end
        stall = 1'b0;
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 64'h0 || imem_pc !== 64'h4) begin
            errors++; $display("FAIL stall_release got v %b ifpc %0h pc %0h exp 1 0 4", if_valid, if_pc, imem_pc);
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        if_ready = 1'b1;
        push(64'h0); push(64'h40); push(64'h44);
        repeat (3) cycle();
        checks++;
        if (if_pc !== 64'h4 || fetch_count !== 32'd1) begin
            errors++; $display("FAIL rd_pre got ifpc %0h cnt %0d exp 4 1", if_pc, fetch_count);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || fetch_count !== 32'd1 || imem_pc !== 64'h40) begin
            errors++;
            $display("FAIL rd_flush got v %b cnt %0d pc %0h exp 0 1 40", if_valid, fetch_count, imem_pc);
        end
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 64'h40 || if_instr !== mem_word(64'h40)) begin
            errors++; $display("FAIL rd_target got v %b ifpc %0h exp 1 40", if_valid, if_pc);
        end
    endtask

    task automatic test_fault();
        do_reset();
        if_ready = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h42;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (imem_pc !== 64'h42 || if_valid !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL flt_redir got pc %0h v %b f %b exp 42 0 0", imem_pc, if_valid, fault);
        end
        cycle();
        checks++;
        if (fault !== 1'b1 || fault_pc !== 64'h42 || if_valid !== 1'b0) begin
            errors++; $display("FAIL flt_raise got f %b fpc %0h v %b exp 1 42 0", fault, fault_pc, if_valid);
        end
        fault_clear = 1'b1;
        cycle();
        fault_clear = 1'b0;
        checks++;
        if (fault !== 1'b0 || imem_pc !== 64'h42) begin
            errors++; $display("FAIL flt_clear got f %b pc %0h exp 0 42", fault, imem_pc);
        end
        cycle();
        checks++;
        if (fault !== 1'b1 || fault_pc !== 64'h42 || if_valid !== 1'b0) begin
            errors++; $display("FAIL flt_refault got f %b fpc %0h v %b exp 1 42 0", fault, fault_pc, if_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h44;
        push(64'h44); push(64'h48);
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b0 || imem_pc !== 64'h44 || if_valid !== 1'b0) begin
            errors++; $display("FAIL flt_recover got f %b pc %0h v %b exp 0 44 0", fault, imem_pc, if_valid);
        end
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 64'h44) begin
            errors++; $display("FAIL flt_resume got v %b ifpc %0h exp 1 44", if_valid, if_pc);
        end
    endtask

    task automatic test_boundary();
        do_reset();
        if_ready = 1'b1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFF8;
        push(64'hFF8); push(64'hFFC);
        cycle();
        redirect_valid = 1'b0;
        repeat (2) cycle();
        checks++;
        if (if_pc !== 64'hFFC || if_valid !== 1'b1 || imem_pc !== 64'h1000) begin
            errors++; $display("FAIL bnd_last got ifpc %0h v %b pc %0h exp ffc 1 1000", if_pc, if_valid, imem_pc);
        end
        cycle();
        checks++;
        if (fault !== 1'b1 || fault_pc !== 64'h1000 || if_valid !== 1'b0 || fetch_count !== 32'd2) begin
            errors++;
            $display("FAIL bnd_fault got f %b fpc %0h v %b cnt %0d exp 1 1000 0 2",
                     fault, fault_pc, if_valid, fetch_count);
        end
        checks++;
        if (sb.size() != 0 || exp_count != 2) begin
            errors++; $display("FAIL bnd_delivered got left %0d accepted %0d exp 0 2", sb.size(), exp_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        if_ready = 1'b1;
        push(64'h0); push(64'h4); push(64'h8); push(64'hC);
        repeat (4) cycle();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (imem_pc !== 64'h0 || if_valid !== 1'b0 || if_pc !== 64'h0 || if_instr !== 32'h0 ||
            fault !== 1'b0 || fault_pc !== 64'h0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got pc %0h v %b ifpc %0h ins %0h f %b fpc %0h cnt %0d exp all zero",
                     imem_pc, if_valid, if_pc, if_instr, fault, fault_pc, fetch_count);
        end
        sb.delete();
        exp_count = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(64'h0); push(64'h4);
        cycle();
        checks++;
        if (imem_pc !== 64'h0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL async_boot got pc %0h v %b exp 0 0", imem_pc, if_valid);
        end
        cycle();
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 64'h0 || imem_pc !== 64'h4) begin
            errors++; $display("FAIL async_restart got v %b ifpc %0h pc %0h exp 1 0 4", if_valid, if_pc, imem_pc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_stall();
        test_redirect_flush();
        test_fault();
        test_boundary();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 The module SHALL have parameter PC_W, default 64, meaning the program counter width.
REQ-003 clk  input  1  The single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 imem_pc  output  PC_W  Current fetch address, driven straight from the PC register to the combinational instruction memory.
REQ-006 imem_instr  input  32  Instruction word returned combinationally for imem_pc.
REQ-007 imem_inv  input  1  High when imem_pc is misaligned (PC[1:0]!=0) or beyond word 1023.
REQ-008 stall  input  1  When high, the block performs no new fetch this cycle.
REQ-009 redirect_valid  input  1  Branch or jump redirect request.
REQ-010 redirect_pc  input  PC_W  Redirect target address.
REQ-011 if_valid  output  1  The output slot holds a valid instruction.
REQ-012 if_ready  input  1  The decode stage accepts the slot.
REQ-013 if_pc, if_instr  output  PC_W, 32  Address and word held in the output slot.
REQ-014 fault  output  1  An invalid-address fault is pending.
REQ-015 fault_pc  output  PC_W  Address that caused the fault.
REQ-016 fault_clear  input  1  Retry the faulting address.
REQ-017 fetch_count  output  32  Count of accepted instructions.

Function
REQ-018 The FSM SHALL have three states: BOOT, RUN and FAULT; BOOT SHALL last exactly one cycle after reset deassertion and then go to RUN without fetching.
REQ-019 A slot is free when if_valid=0 or (if_valid && if_ready); in RUN, with the slot free, stall=0 and imem_inv=0, the block SHALL load {imem_pc, imem_instr} into the slot, set if_valid=1 and set pc<=pc+4.
REQ-020 Fetch latency SHALL be one cycle: the instruction appears on if_* the cycle after its address is on imem_pc; sustained throughput SHALL be one instruction per cycle.
REQ-021 If the slot is not free, or stall=1, the block SHALL hold pc and the slot unchanged, and keep if_pc/if_instr stable while if_valid=1.
REQ-022 A handshake (if_valid && if_ready) with no new fetch SHALL clear if_valid.
REQ-023 In RUN with the slot free, stall=0 and imem_inv=1, the block SHALL NOT load the slot, and SHALL set fault=1, fault_pc<=pc and state<=FAULT with pc held.
REQ-024 In FAULT no fetch SHALL occur; an already valid slot remains until it is accepted.
REQ-025 In FAULT, fault_clear=1 SHALL clear fault and return to RUN, retrying the same pc.
REQ-026 redirect_valid SHALL have top priority in RUN and FAULT: it sets pc<=redirect_pc, clears if_valid (flush, even if if_ready=1 that cycle), clears fault, moves to RUN, and does not fetch that cycle.
REQ-027 Redirect in BOOT SHALL be ignored.
REQ-028 Simultaneous redirect and fault_clear SHALL behave as redirect only.
REQ-029 pc+4 SHALL wrap modulo 2^PC_W.
REQ-030 fetch_count SHALL increment on each if_valid && if_ready that is not flushed by a same-cycle redirect, and SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-031 While reset=1, regardless of clk: pc=RESET_PC, state=BOOT, if_valid=0, if_pc=0, if_instr=0, fault=0, fault_pc=0, fetch_count=0.
REQ-032 Reset asserted mid-operation SHALL discard the slot and any pending fault immediately.

Structure
REQ-033 A shared package SHALL hold the FSM state enum {BOOT, RUN, FAULT}, the constant INSTR_BYTES=4 and the constant IMEM_WORDS=1024.
REQ-034 The output slot SHALL be a single sub-module, fetch_slot (a one-entry valid/ready register with a flush input).

Verification
REQ-035 Bench case: reset with RESET_PC=0, if_ready=1, no stall -> imem_pc sequence 0,0,4,8 over cycles 0-3 and if_pc 0,4,8 from cycle 2; fetch_count=3 after cycle 4.
REQ-036 Bench case: if_ready=0 for 3 cycles with slot holding pc 8 -> if_pc=8 and imem_pc=12 stay stable; when if_ready=1, if_pc goes 12 the next cycle.
REQ-037 Bench case: redirect_valid=1, redirect_pc=0x40 while the slot holds pc 4 with if_ready=1 -> if_valid=0 next cycle, fetch_count unchanged, following if_pc=0x40.
REQ-038 Bench case: redirect to 0x42 -> fault=1, fault_pc=0x42, no if_valid; fault_clear with imem_inv still 1 -> re-fault; redirect to 0x44 -> fault=0 and fetch resumes at 0x44.
REQ-039 Bench case: sequential fetch reaching pc=0xFFC then 0x1000 (word 1024) -> fault with fault_pc=0x1000, and the 0xFFC instruction is still delivered.
REQ-040 Bench case: assert reset asynchronously mid-stream between clock edges -> all outputs reach their reset values before the next edge; after release, BOOT lasts one cycle and fetch restarts at RESET_PC.
